// File: rtl/pad_in_filter_if.sv
// ---------------------------------------------------------------------------
// pad_in_filter_if
//
// Purpose:
//   Groups the pad-side input, the control inputs and the filtered outputs of
//   pad_in_filter into one bundle. Clock and reset stay as plain module ports.
//
// Signals:
//   I        raw pad level, asynchronous to the fabric clock
//   EN       1 = debounce qualification active, 0 = bypass qualification
//   EVT_CLR  synchronous clear of the accepted-edge counter
//   O        filtered level
//   RISE     one-cycle pulse when O goes 0->1
//   FALL     one-cycle pulse when O goes 1->0
//   STABLE   1 while the qualifier is idle
//   EVT_CNT  accepted-edge count, 8 bits, saturating
//
// Modports:
//   master   fabric/pad side: drives I, EN, EVT_CLR; observes the outputs
//   slave    the filter itself
// ---------------------------------------------------------------------------
interface pad_in_filter_if;
    logic       I;
    logic       EN;
    logic       EVT_CLR;
    logic       O;
    logic       RISE;
    logic       FALL;
    logic       STABLE;
    logic [7:0] EVT_CNT;

    modport master (
        output I,
        output EN,
        output EVT_CLR,
        input  O,
        input  RISE,
        input  FALL,
        input  STABLE,
        input  EVT_CNT
    );

    modport slave (
        input  I,
        input  EN,
        input  EVT_CLR,
        output O,
        output RISE,
        output FALL,
        output STABLE,
        output EVT_CNT
    );
endinterface : pad_in_filter_if

// File: rtl/pad_in_filter.sv
// ---------------------------------------------------------------------------
// pad_in_filter
//
// Purpose:
//   Brings a raw, asynchronous pad level into the CLK domain through a
//   synchroniser chain, rejects excursions shorter than DEBOUNCE_CYCLES
//   consecutive differing cycles, and presents a clean level O with
//   registered one-cycle RISE/FALL pulses.
//
// Parameters:
//   SYNC_STAGES      synchroniser depth, legal 2..4
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to accept a new
//                    level, legal 1..255
//   INIT_LEVEL       reset value of the synchroniser chain and of O
//
// Ports:
//   CLK    fabric clock
//   RST_N  asynchronous active-low reset (release is expected to be
//          synchronised to CLK upstream)
//   pin    pad_in_filter_if.slave: I, EN, EVT_CLR in; O, RISE, FALL,
//          STABLE, EVT_CNT out
//
// Latency:
//   A level change on I sampled at edge k appears on O at edge
//   k + SYNC_STAGES - 1 + DEBOUNCE_CYCLES (EN = 1), or at edge
//   k + SYNC_STAGES (EN = 0).
//
// Build option:
//   PAD_IN_FILTER_EVT_CNT_EN  when defined, EVT_CNT counts cycles in which
//   RISE or FALL is high (saturating at 255, cleared by EVT_CLR). When not
//   defined, EVT_CNT is constant zero, EVT_CLR is ignored and no counter
//   flops exist.
// ---------------------------------------------------------------------------
module pad_in_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit INIT_LEVEL      = 1'b0
) (
    input  logic           CLK,
    input  logic           RST_N,
    pad_in_filter_if.slave pin
);

    // The qualifier counts differing cycles already seen; the edge on which
    // the count would reach DEBOUNCE_CYCLES is the accepting edge. This makes
    // the accepted level appear exactly DEBOUNCE_CYCLES edges after the
    // synchronised level first differs from O.
    localparam logic [7:0] QUAL_LAST     = 8'(DEBOUNCE_CYCLES - 1);
    localparam bit         DIRECT_ACCEPT = (DEBOUNCE_CYCLES <= 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_QUAL = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Synchroniser chain: plain flop-to-flop, nothing in between stages.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = pin.I;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Qualifier FSM and output registers
    // -----------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] qual_q,  qual_d;
    logic       o_q,     o_d;
    logic       rise_q,  rise_d;
    logic       fall_q,  fall_d;
    logic       differ;
    logic       accept;

    assign differ = sync_s ^ o_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            qual_q  <= 8'd0;
            o_q     <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            o_q     <= o_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        o_d     = o_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = 1'b0;

        if (!pin.EN) begin
            // Bypass: O tracks the synchronised level every cycle. Any
            // qualification in flight is abandoned and the new level is
            // taken on this same edge.
            state_d = ST_IDLE;
            qual_d  = 8'd0;
            accept  = differ;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    qual_d = 8'd0;
                    if (differ) begin
                        if (DIRECT_ACCEPT) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_QUAL;
                            qual_d  = 8'd1;
                        end
                    end
                end
                ST_QUAL: begin
                    if (!differ) begin
                        // Level went back before qualifying: glitch, no pulse.
                        state_d = ST_IDLE;
                        qual_d  = 8'd0;
                    end else if (qual_q >= QUAL_LAST) begin
                        accept  = 1'b1;
                        state_d = ST_IDLE;
                        qual_d  = 8'd0;
                    end else begin
                        qual_d = qual_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    qual_d  = 8'd0;
                end
            endcase
        end

        // accept is only raised while sync_s differs from O, so the new
        // level alone decides the pulse direction.
        if (accept) begin
            o_d    = sync_s;
            rise_d = sync_s;
            fall_d = ~sync_s;
        end
    end

    assign pin.O      = o_q;
    assign pin.RISE   = rise_q;
    assign pin.FALL   = fall_q;
    assign pin.STABLE = (state_q == ST_IDLE);

    // -----------------------------------------------------------------------
    // Accepted-edge counter
    // -----------------------------------------------------------------------
`ifdef PAD_IN_FILTER_EVT_CNT_EN
    logic [7:0] evt_cnt_q, evt_cnt_d;
    logic       evt_pulse;

    assign evt_pulse = rise_q | fall_q;

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (pin.EVT_CLR) begin
            // A pulse in the clearing cycle is still counted.
            evt_cnt_d = evt_pulse ? 8'd1 : 8'd0;
        end else if (evt_pulse && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evt_cnt_q <= 8'd0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign pin.EVT_CNT = evt_cnt_q;
`else
    logic unused_evt_clr;
    assign unused_evt_clr = pin.EVT_CLR;
    assign pin.EVT_CNT    = 8'd0;
`endif

    // RISE and FALL come from one accept with opposite polarity.
    a_no_double_pulse: assert property (
        @(posedge CLK) disable iff (!RST_N) !(rise_q && fall_q)
    );

endmodule : pad_in_filter

// File: tb/tb_pad_in_filter.sv
// ---------------------------------------------------------------------------
// tb_pad_in_filter
//
// Two filter instances on one clock:
//   dut_a  defaults (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=0)
//   dut_b  SYNC_STAGES=3, DEBOUNCE_CYCLES=1, INIT_LEVEL=1
// Inputs change 1 ns after a rising edge, so they are sampled on the next
// edge; outputs are checked 1 ns after the edge being observed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pad_in_filter;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pad_in_filter_if ifa ();
    pad_in_filter_if ifb ();

    pad_in_filter #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .INIT_LEVEL     (1'b0)
    ) dut_a (
        .CLK  (clk),
        .RST_N(rst_n_a),
        .pin  (ifa)
    );

    pad_in_filter #(
        .SYNC_STAGES    (3),
        .DEBOUNCE_CYCLES(1),
        .INIT_LEVEL     (1'b1)
    ) dut_b (
        .CLK  (clk),
        .RST_N(rst_n_b),
        .pin  (ifb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset values, then the first rise after release with I held high.
    task automatic test_reset;
        logic exp_o, exp_r;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        ifa.I = 1'b1; ifa.EN = 1'b1; ifa.EVT_CLR = 1'b0;
        ifb.I = 1'b1; ifb.EN = 1'b1; ifb.EVT_CLR = 1'b0;
        repeat (3) tick();
        total++; if (ifa.O !== 1'b0) begin bad++; $display("FAIL reset_a_o got=%b want=0", ifa.O); end
        total++; if (ifa.STABLE !== 1'b1) begin bad++; $display("FAIL reset_a_stable got=%b want=1", ifa.STABLE); end
        total++; if ({ifa.RISE, ifa.FALL} !== 2'b00) begin bad++; $display("FAIL reset_a_pulse got=%b want=00", {ifa.RISE, ifa.FALL}); end
        total++; if (ifa.EVT_CNT !== 8'd0) begin bad++; $display("FAIL reset_a_cnt got=%0d want=0", ifa.EVT_CNT); end
        total++; if (ifb.O !== 1'b1) begin bad++; $display("FAIL reset_b_o got=%b want=1", ifb.O); end
        total++; if (ifb.STABLE !== 1'b1) begin bad++; $display("FAIL reset_b_stable got=%b want=1", ifb.STABLE); end
        rst_n_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_o = (i >= 5);
            exp_r = (i == 5);
            total++; if (ifa.O !== exp_o) begin bad++; $display("FAIL reset_rel_o[%0d] got=%b want=%b", i, ifa.O, exp_o); end
            total++; if (ifa.RISE !== exp_r) begin bad++; $display("FAIL reset_rel_rise[%0d] got=%b want=%b", i, ifa.RISE, exp_r); end
            total++; if (ifa.FALL !== 1'b0) begin bad++; $display("FAIL reset_rel_fall[%0d] got=%b want=0", i, ifa.FALL); end
        end
        $display("reset: O=%b after release", ifa.O);
    endtask

    // Three-cycle pulse on I is rejected.
    task automatic test_glitch;
        logic exp_s;
        ifa.I = 1'b0;
        repeat (8) tick();
        total++; if (ifa.O !== 1'b0) begin bad++; $display("FAIL glitch_pre_o got=%b want=0", ifa.O); end
        ifa.I = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) ifa.I = 1'b0;
            exp_s = !(i >= 2 && i <= 4);
            total++; if (ifa.O !== 1'b0) begin bad++; $display("FAIL glitch_o[%0d] got=%b want=0", i, ifa.O); end
            total++; if ({ifa.RISE, ifa.FALL} !== 2'b00) begin bad++; $display("FAIL glitch_pulse[%0d] got=%b want=00", i, {ifa.RISE, ifa.FALL}); end
            total++; if (ifa.STABLE !== exp_s) begin bad++; $display("FAIL glitch_stable[%0d] got=%b want=%b", i, ifa.STABLE, exp_s); end
        end
        $display("glitch: O=%b", ifa.O);
    endtask

    // Four-cycle high accepted at k+5, then fall at k'+5.
    task automatic test_step;
        logic exp_o, exp_r, exp_f, exp_s;
        ifa.I = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 3) ifa.I = 1'b0;
            exp_o = (i >= 5 && i < 9);
            exp_r = (i == 5);
            exp_f = (i == 9);
            exp_s = !((i >= 2 && i <= 4) || (i >= 6 && i <= 8));
            total++; if (ifa.O !== exp_o) begin bad++; $display("FAIL step_o[%0d] got=%b want=%b", i, ifa.O, exp_o); end
            total++; if (ifa.RISE !== exp_r) begin bad++; $display("FAIL step_rise[%0d] got=%b want=%b", i, ifa.RISE, exp_r); end
            total++; if (ifa.FALL !== exp_f) begin bad++; $display("FAIL step_fall[%0d] got=%b want=%b", i, ifa.FALL, exp_f); end
            total++; if (ifa.STABLE !== exp_s) begin bad++; $display("FAIL step_stable[%0d] got=%b want=%b", i, ifa.STABLE, exp_s); end
        end
        $display("step: O=%b", ifa.O);
    endtask

    // EN=0: O follows I two edges later, pulse on each change.
    task automatic test_bypass;
        logic ih [0:15];
        logic exp_o, exp_p, exp_r, exp_f;
        ifa.EN = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ih[i] = i[1];
            ifa.I = ih[i];
            tick();
            exp_o = 1'b0;
            exp_p = 1'b0;
            if (i >= 2) exp_o = ih[i-2];
            if (i >= 3) exp_p = ih[i-3];
            exp_r = exp_o & ~exp_p;
            exp_f = ~exp_o & exp_p;
            total++; if (ifa.O !== exp_o) begin bad++; $display("FAIL bypass_o[%0d] got=%b want=%b", i, ifa.O, exp_o); end
            total++; if (ifa.RISE !== exp_r) begin bad++; $display("FAIL bypass_rise[%0d] got=%b want=%b", i, ifa.RISE, exp_r); end
            total++; if (ifa.FALL !== exp_f) begin bad++; $display("FAIL bypass_fall[%0d] got=%b want=%b", i, ifa.FALL, exp_f); end
            total++; if (ifa.STABLE !== 1'b1) begin bad++; $display("FAIL bypass_stable[%0d] got=%b want=1", i, ifa.STABLE); end
`ifndef PAD_IN_FILTER_EVT_CNT_EN
            total++; if (ifa.EVT_CNT !== 8'd0) begin bad++; $display("FAIL bypass_cnt[%0d] got=%0d want=0", i, ifa.EVT_CNT); end
`endif
        end
        ifa.I = 1'b0;
        repeat (4) tick();
        ifa.EN = 1'b1;
        repeat (2) tick();
        total++; if (ifa.O !== 1'b0) begin bad++; $display("FAIL bypass_end_o got=%b want=0", ifa.O); end
        $display("bypass: O=%b", ifa.O);
    endtask

    // EN 1->0 mid-QUAL takes S at once; EN 0->1 with a short glitch is quiet.
    task automatic test_en_switch;
        logic exp_s;
        ifa.I = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i >= 2) begin
                total++; if (ifa.STABLE !== 1'b0) begin bad++; $display("FAIL en_qual_stable[%0d] got=%b want=0", i, ifa.STABLE); end
            end
        end
        ifa.EN = 1'b0;
        tick();
        total++; if (ifa.O !== 1'b1) begin bad++; $display("FAIL en_abort_o got=%b want=1", ifa.O); end
        total++; if ({ifa.RISE, ifa.FALL} !== 2'b10) begin bad++; $display("FAIL en_abort_pulse got=%b want=10", {ifa.RISE, ifa.FALL}); end
        total++; if (ifa.STABLE !== 1'b1) begin bad++; $display("FAIL en_abort_stable got=%b want=1", ifa.STABLE); end
        tick();
        total++; if (ifa.RISE !== 1'b0) begin bad++; $display("FAIL en_abort_rise2 got=%b want=0", ifa.RISE); end
        ifa.EN = 1'b1;
        ifa.I  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 1) ifa.I = 1'b1;
            exp_s = !(i == 2 || i == 3);
            total++; if (ifa.O !== 1'b1) begin bad++; $display("FAIL en_on_o[%0d] got=%b want=1", i, ifa.O); end
            total++; if ({ifa.RISE, ifa.FALL} !== 2'b00) begin bad++; $display("FAIL en_on_pulse[%0d] got=%b want=00", i, {ifa.RISE, ifa.FALL}); end
            total++; if (ifa.STABLE !== exp_s) begin bad++; $display("FAIL en_on_stable[%0d] got=%b want=%b", i, ifa.STABLE, exp_s); end
        end
        $display("en_switch: O=%b", ifa.O);
    endtask

    // Reset asserted mid-QUAL clears O at once; release gives no pulse.
    task automatic test_midreset;
        ifa.I = 1'b0;
        repeat (4) tick();
        total++; if (ifa.STABLE !== 1'b0) begin bad++; $display("FAIL midrst_qual got=%b want=0", ifa.STABLE); end
        #2 rst_n_a = 1'b0;
        #1;
        total++; if (ifa.O !== 1'b0) begin bad++; $display("FAIL midrst_async_o got=%b want=0", ifa.O); end
        total++; if (ifa.STABLE !== 1'b1) begin bad++; $display("FAIL midrst_async_stable got=%b want=1", ifa.STABLE); end
        total++; if ({ifa.RISE, ifa.FALL} !== 2'b00) begin bad++; $display("FAIL midrst_async_pulse got=%b want=00", {ifa.RISE, ifa.FALL}); end
        repeat (2) tick();
        rst_n_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (ifa.O !== 1'b0) begin bad++; $display("FAIL midrst_rel_o[%0d] got=%b want=0", i, ifa.O); end
            total++; if ({ifa.RISE, ifa.FALL} !== 2'b00) begin bad++; $display("FAIL midrst_rel_pulse[%0d] got=%b want=00", i, {ifa.RISE, ifa.FALL}); end
        end
        $display("midreset: O=%b", ifa.O);
    endtask

    // SYNC_STAGES=3, DEBOUNCE_CYCLES=1: step lands at k+3, never in QUAL.
    task automatic test_small;
        logic exp_o, exp_f;
        rst_n_b = 1'b1;
        repeat (3) tick();
        total++; if (ifb.O !== 1'b1) begin bad++; $display("FAIL small_rel_o got=%b want=1", ifb.O); end
        total++; if ({ifb.RISE, ifb.FALL} !== 2'b00) begin bad++; $display("FAIL small_rel_pulse got=%b want=00", {ifb.RISE, ifb.FALL}); end
        ifb.I = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_o = !(i >= 3);
            exp_f = (i == 3);
            total++; if (ifb.O !== exp_o) begin bad++; $display("FAIL small_o[%0d] got=%b want=%b", i, ifb.O, exp_o); end
            total++; if (ifb.FALL !== exp_f) begin bad++; $display("FAIL small_fall[%0d] got=%b want=%b", i, ifb.FALL, exp_f); end
            total++; if (ifb.RISE !== 1'b0) begin bad++; $display("FAIL small_rise[%0d] got=%b want=0", i, ifb.RISE); end
            total++; if (ifb.STABLE !== 1'b1) begin bad++; $display("FAIL small_stable[%0d] got=%b want=1", i, ifb.STABLE); end
        end
        $display("small: O=%b", ifb.O);
    endtask

`ifdef PAD_IN_FILTER_EVT_CNT_EN
    // Counting, saturation and clear-with-pulse.
    task automatic test_evt;
        ifa.EN = 1'b0;
        ifa.I  = 1'b0;
        ifa.EVT_CLR = 1'b1;
        repeat (4) tick();
        ifa.EVT_CLR = 1'b0;
        tick();
        total++; if (ifa.EVT_CNT !== 8'd0) begin bad++; $display("FAIL evt_clr0 got=%0d want=0", ifa.EVT_CNT); end
        for (int i = 0; i < 10; i++) begin
            ifa.I = ~ifa.I;
            tick();
        end
        repeat (5) tick();
        total++; if (ifa.EVT_CNT !== 8'd10) begin bad++; $display("FAIL evt_ten got=%0d want=10", ifa.EVT_CNT); end
        for (int i = 0; i < 290; i++) begin
            ifa.I = ~ifa.I;
            tick();
        end
        repeat (5) tick();
        total++; if (ifa.EVT_CNT !== 8'd255) begin bad++; $display("FAIL evt_sat got=%0d want=255", ifa.EVT_CNT); end
        ifa.I = 1'b1;
        repeat (3) tick();
        total++; if (ifa.RISE !== 1'b1) begin bad++; $display("FAIL evt_rise got=%b want=1", ifa.RISE); end
        ifa.EVT_CLR = 1'b1;
        tick();
        ifa.EVT_CLR = 1'b0;
        total++; if (ifa.EVT_CNT !== 8'd1) begin bad++; $display("FAIL evt_clr_pulse got=%0d want=1", ifa.EVT_CNT); end
        tick();
        total++; if (ifa.EVT_CNT !== 8'd1) begin bad++; $display("FAIL evt_hold got=%0d want=1", ifa.EVT_CNT); end
        ifa.EVT_CLR = 1'b1;
        tick();
        ifa.EVT_CLR = 1'b0;
        total++; if (ifa.EVT_CNT !== 8'd0) begin bad++; $display("FAIL evt_clr got=%0d want=0", ifa.EVT_CNT); end
        ifa.EN = 1'b1;
        $display("evt: EVT_CNT=%0d", ifa.EVT_CNT);
    endtask
`else
    // Counter absent: EVT_CNT stays zero across pulses and EVT_CLR.
    task automatic test_evt;
        ifa.EN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ifa.I = ~ifa.I;
            ifa.EVT_CLR = i[0];
            tick();
            total++; if (ifa.EVT_CNT !== 8'd0) begin bad++; $display("FAIL evt_off[%0d] got=%0d want=0", i, ifa.EVT_CNT); end
        end
        ifa.EVT_CLR = 1'b0;
        ifa.EN = 1'b1;
        $display("evt: EVT_CNT=%0d", ifa.EVT_CNT);
    endtask
`endif

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        test_reset();
        test_glitch();
        test_step();
        test_bypass();
        test_en_switch();
        test_midreset();
        test_small();
        test_evt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pad_in_filter
